// File: rtl/spi_reg_bridge_if.sv
// Signal bundle between the SPI pins / register block and spi_reg_bridge.
// The slave modport is the bridge's view; master is the SPI host plus register block.
interface spi_reg_bridge_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       frame_err;

    modport slave (
        input  sclk, cs_n, mosi, data_read,
        output miso, read, write, addr, data_write, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, data_read,
        input  miso, read, write, addr, data_write, frame_err
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit frames into single-cycle register reads/writes.
// Define SPI_REG_BRIDGE_AUTO_INC_EN to allow address-incrementing bursts after the first data byte.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_reg_bridge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sh;
    logic [7:0]             tx_sh;
    logic                   is_write;
    logic                   byte_done;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall;
    logic [7:0] rx_next;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign rx_next   = {rx_sh[6:0], mosi_s};

    // cs_n sync chain resets low so a select held across reset never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sclk_sync      <= '0;
            cs_sync        <= '0;
            mosi_sync      <= '0;
            sclk_prev      <= 1'b0;
            cs_prev        <= 1'b0;
            bit_cnt        <= 3'd0;
            rx_sh          <= 8'd0;
            tx_sh          <= 8'd0;
            is_write       <= 1'b0;
            byte_done      <= 1'b0;
            bus.miso       <= 1'b0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.addr       <= 6'd0;
            bus.data_write <= 8'd0;
            bus.frame_err  <= 1'b0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            cs_sync       <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev     <= sclk_s;
            cs_prev       <= cs_s;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.frame_err <= 1'b0;

            // data_read is valid while read is high; capture it and present its MSB at once.
            if (bus.read) begin
                tx_sh    <= bus.data_read;
                bus.miso <= bus.data_read[7];
            end

            case (state)
                IDLE: begin
                    bus.miso <= 1'b0;
                    if (cs_prev && !cs_s) begin
                        state     <= CMD;
                        bit_cnt   <= 3'd0;
                        rx_sh     <= 8'd0;
                        byte_done <= 1'b0;
                    end
                end

                CMD: begin
                    if (cs_s) begin
                        bus.frame_err <= 1'b1;
                        bus.miso      <= 1'b0;
                        state         <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bus.addr <= rx_next[5:0];
                            is_write <= rx_next[7];
                            bus.read <= ~rx_next[7];
                            state    <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (cs_s) begin
                        bus.frame_err <= (bit_cnt != 3'd0) || !byte_done;
                        bus.miso      <= 1'b0;
                        state         <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done <= 1'b1;
                            if (is_write) begin
                                bus.write      <= 1'b1;
                                bus.data_write <= rx_next;
                            end
`ifdef SPI_REG_BRIDGE_AUTO_INC_EN
                            if (!is_write || byte_done)
                                bus.addr <= bus.addr + 6'd1;
                            bus.read <= ~is_write;
`else
                            state <= DONE;
`endif
                        end
                    end else if (sclk_fall && !is_write && bit_cnt != 3'd0) begin
                        // MSB was preloaded, so the first falling edge of a byte keeps it on the line.
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                        bus.miso <= tx_sh[6];
                    end
                end

                DONE: begin
                    if (cs_s) begin
                        bus.miso <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
